// File: rtl/audio_filter_pkg.sv
// Shared constants for the audio filter sequencer: cfg register map, power-up coefficients, FSM states.
// No logic; latency and backpressure are defined by the modules that import it.
package audio_filter_pkg;

    localparam logic [2:0] ADDR_FLT_RATE = 3'd0;
    localparam logic [2:0] ADDR_CX_LO    = 3'd1;
    localparam logic [2:0] ADDR_CX_HI    = 3'd2;
    localparam logic [2:0] ADDR_CX_TAPS  = 3'd3;
    localparam logic [2:0] ADDR_CY0      = 3'd4;
    localparam logic [2:0] ADDR_CY1      = 3'd5;
    localparam logic [2:0] ADDR_CY2      = 3'd6;

    typedef struct packed {
        logic [31:0] flt_rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coef_t;

    localparam coef_t COEF_DEFAULT = '{
        flt_rate: 32'd7056000,
        cx:       40'd4258969,
        cx0:      8'd3,
        cx1:      8'd3,
        cx2:      8'd1,
        cy0:      24'hA123C9,
        cy1:      24'h5DBD9A,
        cy2:      24'hE11EA9
    };

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_RUN,
        ST_MUTE,
        ST_SWAP,
        ST_SETTLE
    } state_t;

    // Clamp a requested filter rate so that 2*rate stays below the accumulator modulus.
    function automatic logic [31:0] sat_rate(input logic [31:0] req, input logic [31:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/audio_ce_gen.sv
// Strobe generator: fixed-divider sample_ce and fractional-rate flt_ce, both registered (1-clk latency).
// No backpressure; acc_clr restarts the fractional phase and suppresses flt_ce for that clk.
module audio_ce_gen #(
    parameter int CLK_RATE   = 16777000,
    parameter int SAMPLE_DIV = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] flt_rate,
    input  logic        acc_clr,
    output logic        flt_ce,
    output logic        sample_ce
);

    localparam int              DW       = $clog2(SAMPLE_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [31:0]     MOD      = 32'(CLK_RATE);

    logic [DW-1:0] div_q, div_d;
    logic          sample_ce_q, sample_ce_d;
    logic [31:0]   acc_q, acc_d, acc_sum;
    logic          flt_ce_q, flt_ce_d;

    always_comb begin
        div_d       = div_q + DW'(1);
        sample_ce_d = (div_q == DIV_LAST);

        // flt_rate is pre-clamped so the sum never exceeds 2*MOD and one subtraction suffices.
        acc_sum  = acc_q + (flt_rate << 1);
        acc_d    = acc_sum;
        flt_ce_d = 1'b0;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_sum >= MOD) begin
            acc_d    = acc_sum - MOD;
            flt_ce_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            sample_ce_q <= 1'b0;
            acc_q       <= '0;
            flt_ce_q    <= 1'b0;
        end else begin
            div_q       <= div_d;
            sample_ce_q <= sample_ce_d;
            acc_q       <= acc_d;
            flt_ce_q    <= flt_ce_d;
        end
    end

    assign flt_ce    = flt_ce_q;
    assign sample_ce = sample_ce_q;

endmodule

// File: rtl/audio_filter_ctrl.sv
// Audio IIR/DC-blocker sequencer: shadow->live coefficient commit via mute/swap/settle, plus power-up gating.
// Outputs registered (1-clk latency); cfg writes always accepted, commits outside RUN dropped with commit_err.
module audio_filter_ctrl
    import audio_filter_pkg::*;
#(
    parameter int CLK_RATE   = 16777000,
    parameter int SAMPLE_DIV = 256,
    parameter int START_FLT  = 3,
    parameter int START_SMP  = 8192,
    parameter int MUTE_SMP   = 64,
    parameter int SETTLE_FLT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_commit,
    output logic        cfg_busy,
    output logic        commit_err,
    output logic        flt_ce,
    output logic        sample_ce,
    output logic        iir_en,
    output logic        mute,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2
);

    localparam logic [31:0] RATE_MAX     = 32'((CLK_RATE - 1) / 2);
    localparam logic [15:0] START_FLT_16 = 16'(START_FLT);
    localparam logic [15:0] START_SMP_16 = 16'(START_SMP);
    localparam logic [15:0] MUTE_SMP_16  = 16'(MUTE_SMP);
    localparam logic [15:0] SETTLE_16    = 16'(SETTLE_FLT);

    coef_t       shadow_q, shadow_d;
    coef_t       live_q, live_d;
    state_t      state_q, state_d;
    logic [15:0] flt_cnt_q, flt_cnt_d, flt_inc;
    logic [15:0] smp_cnt_q, smp_cnt_d, smp_inc;
    logic        mute_q, mute_d;
    logic        iir_en_q, iir_en_d;
    logic        commit_err_q, commit_err_d;
    logic        acc_clr;

    audio_ce_gen #(
        .CLK_RATE   (CLK_RATE),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_ce_gen (
        .clk       (clk),
        .reset     (reset),
        .flt_rate  (live_q.flt_rate),
        .acc_clr   (acc_clr),
        .flt_ce    (flt_ce),
        .sample_ce (sample_ce)
    );

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_FLT_RATE: shadow_d.flt_rate   = sat_rate(cfg_wdata, RATE_MAX);
                ADDR_CX_LO:    shadow_d.cx[31:0]   = cfg_wdata;
                ADDR_CX_HI:    shadow_d.cx[39:32]  = cfg_wdata[7:0];
                ADDR_CX_TAPS: begin
                    shadow_d.cx0 = cfg_wdata[7:0];
                    shadow_d.cx1 = cfg_wdata[15:8];
                    shadow_d.cx2 = cfg_wdata[23:16];
                end
                ADDR_CY0:      shadow_d.cy0 = cfg_wdata[23:0];
                ADDR_CY1:      shadow_d.cy1 = cfg_wdata[23:0];
                ADDR_CY2:      shadow_d.cy2 = cfg_wdata[23:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        flt_cnt_d    = flt_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        mute_d       = mute_q;
        iir_en_d     = iir_en_q;
        live_d       = live_q;
        acc_clr      = 1'b0;
        commit_err_d = cfg_commit && (state_q != ST_RUN);
        flt_inc      = flt_cnt_q + {15'd0, flt_ce};
        smp_inc      = smp_cnt_q + {15'd0, sample_ce};

        case (state_q)
            ST_STARTUP: begin
                // Both gates count independently; each saturates once its target is met.
                if (flt_cnt_q < START_FLT_16) flt_cnt_d = flt_inc;
                if (smp_cnt_q < START_SMP_16) smp_cnt_d = smp_inc;
                iir_en_d = (flt_cnt_d >= START_FLT_16);
                mute_d   = (smp_cnt_d < START_SMP_16);
                if (iir_en_d && !mute_d) begin
                    state_d   = ST_RUN;
                    flt_cnt_d = '0;
                    smp_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (cfg_commit) begin
                    state_d   = ST_MUTE;
                    mute_d    = 1'b1;
                    flt_cnt_d = '0;
                    smp_cnt_d = '0;
                end
            end
            ST_MUTE: begin
                smp_cnt_d = smp_inc;
                if (smp_cnt_d == MUTE_SMP_16) begin
                    state_d   = ST_SWAP;
                    iir_en_d  = 1'b0;
                    smp_cnt_d = '0;
                end
            end
            ST_SWAP: begin
                // Every live field and the rate phase change on this single edge.
                live_d    = shadow_q;
                acc_clr   = 1'b1;
                iir_en_d  = 1'b1;
                flt_cnt_d = '0;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                flt_cnt_d = flt_inc;
                if (flt_cnt_d == SETTLE_16) begin
                    state_d   = ST_RUN;
                    mute_d    = 1'b0;
                    flt_cnt_d = '0;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_STARTUP;
            shadow_q     <= COEF_DEFAULT;
            live_q       <= COEF_DEFAULT;
            flt_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            mute_q       <= 1'b1;
            iir_en_q     <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            live_q       <= live_d;
            flt_cnt_q    <= flt_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            mute_q       <= mute_d;
            iir_en_q     <= iir_en_d;
            commit_err_q <= commit_err_d;
        end
    end

    assign cfg_busy   = (state_q != ST_RUN);
    assign commit_err = commit_err_q;
    assign mute       = mute_q;
    assign iir_en     = iir_en_q;
    assign flt_rate   = live_q.flt_rate;
    assign cx         = live_q.cx;
    assign cx0        = live_q.cx0;
    assign cx1        = live_q.cx1;
    assign cx2        = live_q.cx2;
    assign cy0        = live_q.cy0;
    assign cy1        = live_q.cy1;
    assign cy2        = live_q.cy2;

endmodule

// File: tb/tb_audio_filter_ctrl.sv
// Bench for audio_filter_ctrl: directed sequence plus random cfg writes, checked every clk against a
// closed-form model (tick counts as floor(n*2*rate/CLK_RATE), sample pulses at multiples of the divider).
module tb_audio_filter_ctrl;

    localparam longint CLK = 16777000;
    localparam int     DIV = 8;
    localparam int     SF  = 3;
    localparam int     SS  = 6;
    localparam int     MS  = 5;
    localparam int     STL = 16;
    localparam logic [31:0] RMAX = 32'd8388499;

    typedef struct packed {
        logic [31:0] flt_rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } mcoef_t;

    localparam mcoef_t DEF = '{32'd7056000, 40'd4258969, 8'd3, 8'd3, 8'd1,
                               24'hA123C9, 24'h5DBD9A, 24'hE11EA9};

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we, cfg_commit;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_busy, commit_err, flt_ce, sample_ce, iir_en, mute;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;

    wire [167:0] live_dut = {flt_rate, cx, cx0, cx1, cx2, cy0, cy1, cy2};

    int     checks = 0;
    int     errors = 0;
    longint n_flt, n_smp;
    int     tot_flt, tot_smp, dut_flt, dut_smp;
    bit     in_run, swap_now;
    mcoef_t m_live, m_shadow;

    always #5 clk = ~clk;

    audio_filter_ctrl #(
        .CLK_RATE(16777000), .SAMPLE_DIV(DIV), .START_FLT(SF),
        .START_SMP(SS), .MUTE_SMP(MS), .SETTLE_FLT(STL)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .commit_err(commit_err), .flt_ce(flt_ce), .sample_ce(sample_ce),
        .iir_en(iir_en), .mute(mute), .flt_rate(flt_rate), .cx(cx),
        .cx0(cx0), .cx1(cx1), .cx2(cx2), .cy0(cy0), .cy1(cy1), .cy2(cy2)
    );

    function automatic logic exp_flt_at(input longint n, input longint r);
        if (n <= 0) return 1'b0;
        return ((n * 2 * r) / CLK) != (((n - 1) * 2 * r) / CLK);
    endfunction

    function automatic logic exp_smp_at(input longint n);
        return (n > 0) && ((n % DIV) == 0);
    endfunction

    task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_live = DEF; m_shadow = DEF;
        n_flt = 0; n_smp = 0; in_run = 0; swap_now = 0;
        tot_flt = 0; tot_smp = 0; dut_flt = 0; dut_smp = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_mute", mute, 1'b1);
        chk("rst_iir_en", iir_en, 1'b0);
        chk("rst_busy", cfg_busy, 1'b1);
        chk("rst_flt_ce", flt_ce, 1'b0);
        chk("rst_sample_ce", sample_ce, 1'b0);
        chk("rst_commit_err", commit_err, 1'b0);
        chk("rst_live", live_dut, DEF);
    endtask

    task automatic tick();
        logic pend_err;
        pend_err = cfg_commit && !in_run;
        if (exp_flt_at(n_flt, m_live.flt_rate)) tot_flt++;
        if (exp_smp_at(n_smp)) tot_smp++;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        n_smp++;
        if (swap_now) begin
            n_flt = 0;
            m_live = m_shadow;
            swap_now = 0;
        end else begin
            n_flt++;
        end
        chk("flt_ce", flt_ce, exp_flt_at(n_flt, m_live.flt_rate));
        chk("sample_ce", sample_ce, exp_smp_at(n_smp));
        chk("commit_err", commit_err, pend_err);
        chk("live", live_dut, m_live);
        if (flt_ce) dut_flt++;
        if (sample_ce) dut_smp++;
    endtask

    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        case (a)
            3'd0: m_shadow.flt_rate = (d > RMAX) ? RMAX : d;
            3'd1: m_shadow.cx[31:0] = d;
            3'd2: m_shadow.cx[39:32] = d[7:0];
            3'd3: begin m_shadow.cx0 = d[7:0]; m_shadow.cx1 = d[15:8]; m_shadow.cx2 = d[23:16]; end
            3'd4: m_shadow.cy0 = d[23:0];
            3'd5: m_shadow.cy1 = d[23:0];
            3'd6: m_shadow.cy2 = d[23:0];
            default: ;
        endcase
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        drive_wr(a, d);
        tick();
    endtask

    task automatic startup_phase();
        int guard;
        guard = 0;
        while (!(tot_flt >= SF && tot_smp >= SS) && guard < 5000) begin
            tick();
            guard++;
            chk("iir_en_start", iir_en, tot_flt >= SF);
            chk("mute_start", mute, tot_smp < SS);
            chk("busy_start", cfg_busy, !(tot_flt >= SF && tot_smp >= SS));
        end
        chk("startup_done", cfg_busy, 1'b0);
        in_run = 1;
    endtask

    task automatic commit_seq(input bit extra_commit, input bit abort_settle,
                              input bit with_wr, input logic [2:0] a, input logic [31:0] d);
        int c;
        int guard;
        bit extra_done;
        c = 0; guard = 0; extra_done = 0;
        cfg_commit = 1'b1;
        if (with_wr) drive_wr(a, d);
        tick();
        in_run = 0;
        chk("mute_on_commit", mute, 1'b1);
        chk("busy_on_commit", cfg_busy, 1'b1);
        while (guard < 2000) begin
            if (exp_smp_at(n_smp)) c++;
            chk("mute_hold", mute, 1'b1);
            if (c == MS) break;
            if (extra_commit && !extra_done && c == 2) begin
                cfg_commit = 1'b1;
                extra_done = 1;
            end
            tick();
            guard++;
        end
        chk("mute_count", c, MS);
        tick();
        chk("iir_en_swap", iir_en, 1'b0);
        chk("mute_swap", mute, 1'b1);
        swap_now = 1;
        tick();
        chk("iir_en_settle", iir_en, 1'b1);
        c = 0; guard = 0;
        while (guard < 2000) begin
            if (exp_flt_at(n_flt, m_live.flt_rate)) c++;
            chk("mute_settle", mute, 1'b1);
            if (abort_settle && c == 4) begin
                #2 reset = 1'b1;
                #1 check_reset_outputs();
                return;
            end
            if (c == STL) break;
            tick();
            guard++;
        end
        chk("settle_count", c, STL);
        tick();
        in_run = 1;
        chk("mute_run", mute, 1'b0);
        chk("busy_run", cfg_busy, 1'b0);
        chk("iir_en_run", iir_en, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        reset = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1 check_reset_outputs();
        startup_phase();

        repeat (2000) tick();
        chk("flt_total", dut_flt, (n_flt * 2 * 7056000) / CLK);
        chk("smp_total", dut_smp, n_smp / DIV);

        wr(3'd4, 32'h00123456);
        commit_seq(0, 0, 0, 3'd0, 32'd0);
        chk("cy0_new", cy0, 24'h123456);

        commit_seq(1, 0, 1, 3'd5, 32'hABCDEF01);
        chk("cy1_same_clk", cy1, 24'hCDEF01);
        repeat (100) begin
            tick();
            chk("busy_idle", cfg_busy, 1'b0);
            chk("mute_idle", mute, 1'b0);
        end

        wr(3'd0, 32'hFFFFFFFF);
        commit_seq(0, 0, 0, 3'd0, 32'd0);
        chk("flt_rate_sat", flt_rate, 32'd8388499);
        repeat (300) tick();

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                ra = 3'($urandom_range(7, 0));
                rd = (ra == 3'd0) ? $urandom_range(32'hFFFFFFFF, 32'd2000000) : $urandom;
                wr(ra, rd);
            end
            commit_seq(0, 0, 0, 3'd0, 32'd0);
            repeat (50) tick();
        end

        wr(3'd6, 32'h00C0FFEE);
        commit_seq(0, 1, 0, 3'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk) reset = 1'b0;
        #1 check_reset_outputs();
        startup_phase();
        repeat (200) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
